// File: rtl/ten_gig_eth_pcs_pma_sync_pkg.sv
// Shared constants and helpers for the PCS/PMA status-bit synchroniser.
// Edge-pulse generation is enabled by defining TEN_GIG_ETH_PCS_PMA_SYNC_EDGE_EN.
package ten_gig_eth_pcs_pma_sync_pkg;

    localparam int SYNC_MIN_STAGES   = 2;
    localparam int FILTER_MIN_CYCLES = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

    // A filter of one cycle still needs a 1-bit counter to keep the logic uniform.
    function automatic int cnt_width(input int cycles);
        return (clog2(cycles) < 1) ? 1 : clog2(cycles);
    endfunction

endpackage

// File: rtl/ten_gig_eth_pcs_pma_sync_filter_ch.sv
// One channel: ASYNC_REG synchroniser chain, consecutive-cycle stability filter
// and optional rise/fall pulses (TEN_GIG_ETH_PCS_PMA_SYNC_EDGE_EN).
module ten_gig_eth_pcs_pma_sync_filter_ch
    import ten_gig_eth_pcs_pma_sync_pkg::*;
#(
    parameter int   N     = 3,
    parameter int   F     = 8,
    parameter logic R_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int             CW      = cnt_width(F);
    localparam logic [CW-1:0]  CNT_MAX = CW'(F - 1);

    (* ASYNC_REG = "TRUE", shreg_extract = "no" *) logic [N-1:0] sync_q;
    logic          s;
    logic          filt;
    logic [CW-1:0] cnt;
    logic          accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {N{R_VAL}};
        else     sync_q <= {sync_q[N-2:0], d};
    end

    assign s      = sync_q[N-1];
    assign accept = (s != filt) && (cnt == CNT_MAX);

    // Any matching cycle discards a partial count, so only an unbroken run is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= R_VAL;
            cnt  <= '0;
        end else if (s == filt) begin
            cnt  <= '0;
        end else if (accept) begin
            filt <= s;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

    assign q = filt;

`ifdef TEN_GIG_ETH_PCS_PMA_SYNC_EDGE_EN
    // Pulses load on the same edge as filt, so they line up with the new data_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept & s;
            fall <= accept & ~s;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/ten_gig_eth_pcs_pma_sync_filter.sv
// Multi-channel synchroniser + glitch filter for asynchronous PMA status pins.
// Define TEN_GIG_ETH_PCS_PMA_SYNC_EDGE_EN to generate rise/fall pulses (else tied 0).
module ten_gig_eth_pcs_pma_sync_filter
    import ten_gig_eth_pcs_pma_sync_pkg::*;
#(
    parameter int                 C_WIDTH         = 4,
    parameter int                 C_NUM_SYNC_REGS = 3,
    parameter logic [C_WIDTH-1:0] C_RVAL          = {C_WIDTH{1'b0}},
    parameter int                 C_FILTER_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [C_WIDTH-1:0] data_in,
    output logic [C_WIDTH-1:0] data_out,
    output logic [C_WIDTH-1:0] rise,
    output logic [C_WIDTH-1:0] fall
);

    generate
        if (C_NUM_SYNC_REGS < SYNC_MIN_STAGES) begin : g_bad_sync
            $error("C_NUM_SYNC_REGS must be at least %0d", SYNC_MIN_STAGES);
        end
        if (C_FILTER_CYCLES < FILTER_MIN_CYCLES) begin : g_bad_filt
            $error("C_FILTER_CYCLES must be at least %0d", FILTER_MIN_CYCLES);
        end
    endgenerate

    // Channels are independent; no coherency across bits is attempted.
    for (genvar i = 0; i < C_WIDTH; i++) begin : g_ch
        ten_gig_eth_pcs_pma_sync_filter_ch #(
            .N     (C_NUM_SYNC_REGS),
            .F     (C_FILTER_CYCLES),
            .R_VAL (C_RVAL[i])
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .d    (data_in[i]),
            .q    (data_out[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule

// File: tb/tb_ten_gig_eth_pcs_pma_sync_filter.sv
// Bench for ten_gig_eth_pcs_pma_sync_filter: default-timing DUT (RVAL 1010) plus an N=2/F=1 DUT.
// Expectations for rise/fall follow TEN_GIG_ETH_PCS_PMA_SYNC_EDGE_EN.
module tb_ten_gig_eth_pcs_pma_sync_filter;

`ifdef TEN_GIG_ETH_PCS_PMA_SYNC_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din, dout, rise, fall;
    logic [3:0] din_f1, dout_f1, rise_f1, fall_f1;

    always #5 clk = ~clk;

    ten_gig_eth_pcs_pma_sync_filter #(
        .C_WIDTH(4), .C_NUM_SYNC_REGS(3), .C_RVAL(4'b1010), .C_FILTER_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .data_in(din), .data_out(dout), .rise(rise), .fall(fall)
    );

    ten_gig_eth_pcs_pma_sync_filter #(
        .C_WIDTH(4), .C_NUM_SYNC_REGS(2), .C_RVAL(4'b0000), .C_FILTER_CYCLES(1)
    ) dut_f1 (
        .clk(clk), .rst(rst), .data_in(din_f1), .data_out(dout_f1), .rise(rise_f1), .fall(fall_f1)
    );

    typedef struct {
        logic [3:0] din;
        int         hold;
        logic [3:0] dout;
        logic [3:0] rise_m;
        logic [3:0] fall_m;
    } vec_t;

    vec_t vecs[7];
    vec_t sb[$];
    int   tests = 0;
    int   failed = 0;
    int   rise_cnt[4];
    int   fall_cnt[4];
    int   both_cnt;

    function automatic logic [3:0] ex(input logic [3:0] v);
        return EDGE_EN ? v : 4'b0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        both_cnt = 0;
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rise_cnt[i] += int'(rise[i]);
                fall_cnt[i] += int'(fall[i]);
                if (rise[i] && fall[i]) both_cnt++;
            end
        end
    endtask

    // Bit i set when channel i pulsed exactly once; top bit flags repeated or coincident pulses.
    task automatic check_pulses(input string name, input logic [3:0] er, input logic [3:0] ef);
        logic [4:0] ar, af;
        ar = '0;
        af = '0;
        for (int i = 0; i < 4; i++) begin
            ar[i] = (rise_cnt[i] == 1);
            af[i] = (fall_cnt[i] == 1);
            if (rise_cnt[i] > 1 || both_cnt != 0) ar[4] = 1'b1;
            if (fall_cnt[i] > 1 || both_cnt != 0) af[4] = 1'b1;
        end
        check({name, "_rise"}, {27'd0, ar}, {28'd0, ex(er)});
        check({name, "_fall"}, {27'd0, af}, {28'd0, ex(ef)});
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{4'b0000, 14, 4'b0000, 4'b0000, 4'b0101};
        vecs[1] = '{4'b0001, 14, 4'b0001, 4'b0001, 4'b0000};
        vecs[2] = '{4'b1111, 14, 4'b1111, 4'b1110, 4'b0000};
        vecs[3] = '{4'b1111, 14, 4'b1111, 4'b0000, 4'b0000};
        vecs[4] = '{4'b0110, 14, 4'b0110, 4'b0000, 4'b1001};
        vecs[5] = '{4'b1001, 14, 4'b1001, 4'b1001, 4'b0110};
        vecs[6] = '{4'b0000, 14, 4'b0000, 4'b0000, 4'b1001};

        // Reset with inputs opposite to the reset value.
        rst = 1'b1;
        din = 4'b0101;
        din_f1 = 4'b0000;
        clear_counts();
        tick(3);
        check("rst_dout", dout, 4'b1010);
        check("rst_rise", rise, 4'b0000);
        check("rst_fall", fall, 4'b0000);
        check("rst_f1_dout", dout_f1, 4'b0000);
        rst = 1'b0;
        tick(10);
        check("rel_e10_dout", dout, 4'b1010);
        check("rel_e10_rise", rise, 4'b0000);
        tick();
        check("rel_e11_dout", dout, 4'b0101);
        check("rel_e11_rise", rise, ex(4'b0101));
        check("rel_e11_fall", fall, ex(4'b1010));
        tick();
        check("rel_e12_rise", rise, 4'b0000);
        check("rel_e12_fall", fall, 4'b0000);

        // Table of steady steps through the scoreboard.
        for (int t = 0; t < 7; t++) begin
            din = vecs[t].din;
            sb.push_back(vecs[t]);
            clear_counts();
            tick(vecs[t].hold);
            v = sb.pop_front();
            check($sformatf("vec%0d_dout", t), dout, v.dout);
            check_pulses($sformatf("vec%0d", t), v.rise_m, v.fall_m);
        end

        // Channel 0 step with exact edge timing.
        din = 4'b0001;
        clear_counts();
        tick(10);
        check("step_e10_dout", dout, 4'b0000);
        tick();
        check("step_e11_dout", dout, 4'b0001);
        check("step_e11_rise", rise, ex(4'b0001));
        check("step_e11_fall", fall, 4'b0000);
        tick();
        check("step_e12_rise", rise, 4'b0000);
        tick(2);
        check_pulses("step", 4'b0001, 4'b0000);

        // 7-cycle glitch on channel 1 is rejected.
        din = 4'b0011;
        clear_counts();
        tick(7);
        din = 4'b0001;
        tick(20);
        check("glitch7_dout", dout, 4'b0001);
        check_pulses("glitch7", 4'b0000, 4'b0000);

        // 8-cycle pulse is accepted, fall follows 8 cycles after the rise.
        din = 4'b0011;
        clear_counts();
        tick(8);
        din = 4'b0001;
        tick(3);
        check("pulse8_e11_dout", dout, 4'b0011);
        check("pulse8_e11_rise", rise, ex(4'b0010));
        tick(7);
        check("pulse8_e18_dout", dout, 4'b0011);
        tick();
        check("pulse8_e19_dout", dout, 4'b0001);
        check("pulse8_e19_fall", fall, ex(4'b0010));
        tick(5);
        check_pulses("pulse8", 4'b0010, 4'b0010);

        // Reset mid-count: asynchronous, then a full restart.
        din = 4'b0011;
        tick(8);
        #2 rst = 1'b1;
        #1;
        check("rstcnt_async_dout", dout, 4'b1010);
        check("rstcnt_async_rise", rise, 4'b0000);
        clear_counts();
        tick(2);
        rst = 1'b0;
        tick(10);
        check("rstcnt_e10_dout", dout, 4'b1010);
        check_pulses("rstcnt_quiet", 4'b0000, 4'b0000);
        tick();
        check("rstcnt_e11_dout", dout, 4'b0011);
        check("rstcnt_e11_rise", rise, ex(4'b0001));
        check("rstcnt_e11_fall", fall, ex(4'b1000));
        tick(3);

        // Reset while a fall pulse is high.
        din = 4'b0000;
        tick(10);
        @(posedge clk);
        #2;
        check("rstpulse_pre_fall", fall, ex(4'b0011));
        rst = 1'b1;
        #1;
        check("rstpulse_async_fall", fall, 4'b0000);
        check("rstpulse_async_dout", dout, 4'b1010);
        @(negedge clk);
        tick();
        rst = 1'b0;
        clear_counts();
        tick(10);
        check("rstpulse_e10_dout", dout, 4'b1010);
        check_pulses("rstpulse_quiet", 4'b0000, 4'b0000);
        tick();
        check("rstpulse_e11_dout", dout, 4'b0000);
        check("rstpulse_e11_fall", fall, ex(4'b1010));
        tick(3);

        // N=2, F=1: a single-cycle pulse passes through three cycles later.
        din_f1 = 4'b0001;
        tick();
        din_f1 = 4'b0000;
        check("f1_e1_dout", dout_f1, 4'b0000);
        tick();
        check("f1_e2_dout", dout_f1, 4'b0000);
        tick();
        check("f1_e3_dout", dout_f1, 4'b0001);
        check("f1_e3_rise", rise_f1, ex(4'b0001));
        tick();
        check("f1_e4_dout", dout_f1, 4'b0000);
        check("f1_e4_rise", rise_f1, 4'b0000);
        check("f1_e4_fall", fall_f1, ex(4'b0001));
        tick();
        check("f1_e5_fall", fall_f1, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
